ula_seq: RTL and testbench
==========================

ULA_SEQ -- requirements
Module: ula_seq

Interface
REQ-001 The module SHALL have parameter N, default 8, meaning operand width in bits (legal range 2..32).
REQ-002 The module SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1 bit: reset; one clock, reset asynchronous and active-low.
REQ-004 The module SHALL have port start, input, 1 bit: operation request, sampled on clk rising edge.
REQ-005 The module SHALL have ports A and B, input, N bits each: unsigned operands, sampled with start.
REQ-006 The module SHALL have port S, input, 4 bits: operation select, sampled with start.
REQ-007 The module SHALL have port F, output, 2N bits: registered result.
REQ-008 The module SHALL have ports Z, C, V and E, output, 1 bit each: zero, carry/borrow, signed overflow and illegal-op flags, all registered.
REQ-009 The module SHALL have port busy, output, 1 bit: high while a multi-cycle operation runs.
REQ-010 The module SHALL have port done, output, 1 bit: one-cycle pulse marking an F/flag update.

Function
REQ-011 Op codes SHALL be: 0000 A&B; 0001 A|B; 0010 A+B; 0011 ~A; 0100 A&~B; 0101 A|~B; 0110 A-B; 0111 A<B unsigned (F=1/0); 1000 A*B unsigned; 1001 A<<B[log2N-1:0]; 1010 A>>B[log2N-1:0] logical; 1011..1111 reserved.
REQ-012 Width rules SHALL be: logic/shift/SUB results N bits, zero-extended to 2N; ADD result N+1 bits (carry in bit N), zero-extended; MUL result full 2N bits.
REQ-013 The FSM SHALL have states IDLE and MUL.
REQ-014 In IDLE, start=1 with S≠1000 SHALL update F and flags, and assert done, at that same edge (latency 1); busy stays 0 and the state stays IDLE.
REQ-015 In IDLE, start=1 with S=1000 SHALL capture A and B, set busy=1 and enter MUL.
REQ-016 MUL SHALL be iterative shift-add, one partial product per cycle, for N cycles.
REQ-017 On the edge ending the Nth cycle, MUL SHALL write F, pulse done, clear busy and return to IDLE; total latency is N+1 edges from the start edge.
REQ-018 start SHALL be ignored while busy=1; A, B and S changes during MUL SHALL NOT affect the result.
REQ-019 start on the same edge that MUL completes SHALL be ignored; a new start is accepted from the following edge.
REQ-020 Z SHALL equal (F==0) for every update.
REQ-021 C SHALL be the carry-out for ADD and the borrow (A<B) for SUB, and 0 for all other ops.
REQ-022 V SHALL be the two's-complement overflow of the N-bit ADD/SUB and 0 for all other ops.
REQ-023 A reserved op code SHALL produce F=0, Z=1, C=0, V=0, E=1 and a done pulse; every legal op SHALL clear E.
REQ-024 F and all flags SHALL hold their values between done pulses.
REQ-025 done SHALL be high for exactly one cycle per accepted operation.

Reset
REQ-026 rst_n=0 SHALL immediately force F=0, Z=0, C=0, V=0, E=0, busy=0, done=0 and state IDLE, regardless of clk.
REQ-027 Reset during MUL SHALL abort the operation with no done pulse.
REQ-028 The first rising edge with rst_n=1 SHALL accept start normally.

Verification (N=8)
REQ-029 The bench SHALL check: ADD A=200, B=100 -> next edge F=0x012C, C=1, V=0, Z=0, done=1 for 1 cycle, busy=0.
REQ-030 The bench SHALL check: ADD A=100, B=100 -> F=0x00C8, V=1, C=0; SUB A=5, B=7 -> F=0x00FE, C=1, V=0.
REQ-031 The bench SHALL check: MUL A=255, B=255 -> busy=1 for 8 cycles; F=0xFE01 and done on the 9th edge; a start pulse (ADD) issued mid-MUL is ignored.
REQ-032 The bench SHALL check: rst_n low during MUL cycle 4 -> all outputs 0 at once, no done; after release, SLT A=3, B=9 -> F=1.
REQ-033 The bench SHALL check: S=1111 -> F=0, Z=1, E=1, done pulse; a following op AND A=0xF0, B=0x0F -> F=0, Z=1, E=0.
REQ-034 The bench SHALL check: SHL A=0x81, B=1 -> F=0x0002; SHR A=0x81, B=7 -> F=0x0001.

Source files
------------

// File: rtl/ula_seq.sv
// Sequential ALU: single-cycle logic/arithmetic/shift ops plus an N-cycle
// iterative shift-add multiplier, with registered result and status flags.
module ula_seq #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   A,
  input  logic [N-1:0]   B,
  input  logic [3:0]     S,
  output logic [2*N-1:0] F,
  output logic           Z,
  output logic           C,
  output logic           V,
  output logic           E,
  output logic           busy,
  output logic           done
);

  localparam int SH = $clog2(N);
  localparam int CW = $clog2(N);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_NOTA = 4'b0011;
  localparam logic [3:0] OP_ANDN = 4'b0100;
  localparam logic [3:0] OP_ORN  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [3:0] OP_SHL  = 4'b1001;
  localparam logic [3:0] OP_SHR  = 4'b1010;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

  state_t state_reg, state_next;

  logic [2*N-1:0] f_reg, f_next;
  logic           z_reg, z_next;
  logic           c_reg, c_next;
  logic           v_reg, v_next;
  logic           e_reg, e_next;
  logic           busy_reg, busy_next;
  logic           done_reg, done_next;

  logic [2*N-1:0] mcand_reg, mcand_next;
  logic [2*N-1:0] acc_reg, acc_next;
  logic [N-1:0]   mplier_reg, mplier_next;
  logic [CW-1:0]  cnt_reg, cnt_next;

  logic [N:0]     sum;
  logic [N:0]     diff;
  logic [N-1:0]   shl_res;
  logic [N-1:0]   shr_res;
  logic [2*N-1:0] acc_sum;

  logic [2*N-1:0] alu_f;
  logic           alu_c;
  logic           alu_v;
  logic           alu_e;

  assign sum     = {1'b0, A} + {1'b0, B};
  assign diff    = {1'b0, A} - {1'b0, B};
  assign shl_res = A << B[SH-1:0];
  assign shr_res = A >> B[SH-1:0];
  assign acc_sum = acc_reg + (mplier_reg[0] ? mcand_reg : '0);

  // Single-cycle datapath; the MUL code is handled by the sequencer instead.
  always_comb begin
    alu_f = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    alu_e = 1'b0;
    case (S)
      OP_AND:  alu_f = {{N{1'b0}}, A & B};
      OP_OR:   alu_f = {{N{1'b0}}, A | B};
      OP_ADD: begin
        alu_f = {{(N-1){1'b0}}, sum};
        alu_c = sum[N];
        alu_v = (A[N-1] == B[N-1]) && (sum[N-1] != A[N-1]);
      end
      OP_NOTA: alu_f = {{N{1'b0}}, ~A};
      OP_ANDN: alu_f = {{N{1'b0}}, A & ~B};
      OP_ORN:  alu_f = {{N{1'b0}}, A | ~B};
      OP_SUB: begin
        alu_f = {{N{1'b0}}, diff[N-1:0]};
        alu_c = diff[N];
        alu_v = (A[N-1] != B[N-1]) && (diff[N-1] != A[N-1]);
      end
      OP_SLT:  alu_f = {{(2*N-1){1'b0}}, (A < B)};
      OP_MUL:  alu_f = '0;
      OP_SHL:  alu_f = {{N{1'b0}}, shl_res};
      OP_SHR:  alu_f = {{N{1'b0}}, shr_res};
      default: alu_e = 1'b1;
    endcase
  end

  always_comb begin
    state_next  = state_reg;
    f_next      = f_reg;
    z_next      = z_reg;
    c_next      = c_reg;
    v_next      = v_reg;
    e_next      = e_reg;
    busy_next   = busy_reg;
    done_next   = 1'b0;
    mcand_next  = mcand_reg;
    acc_next    = acc_reg;
    mplier_next = mplier_reg;
    cnt_next    = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          if (S == OP_MUL) begin
            mcand_next  = {{N{1'b0}}, A};
            mplier_next = B;
            acc_next    = '0;
            cnt_next    = '0;
            busy_next   = 1'b1;
            state_next  = MUL;
          end else begin
            f_next    = alu_f;
            z_next    = (alu_f == '0);
            c_next    = alu_c;
            v_next    = alu_v;
            e_next    = alu_e;
            done_next = 1'b1;
          end
        end
      end
      MUL: begin
        // One partial product per cycle; start is not looked at here.
        acc_next    = acc_sum;
        mcand_next  = mcand_reg << 1;
        mplier_next = mplier_reg >> 1;
        cnt_next    = cnt_reg + CW'(1);
        if (cnt_reg == CW'(N - 1)) begin
          f_next     = acc_sum;
          z_next     = (acc_sum == '0);
          c_next     = 1'b0;
          v_next     = 1'b0;
          e_next     = 1'b0;
          done_next  = 1'b1;
          busy_next  = 1'b0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      f_reg      <= '0;
      z_reg      <= 1'b0;
      c_reg      <= 1'b0;
      v_reg      <= 1'b0;
      e_reg      <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      mcand_reg  <= '0;
      acc_reg    <= '0;
      mplier_reg <= '0;
      cnt_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      f_reg      <= f_next;
      z_reg      <= z_next;
      c_reg      <= c_next;
      v_reg      <= v_next;
      e_reg      <= e_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
      mcand_reg  <= mcand_next;
      acc_reg    <= acc_next;
      mplier_reg <= mplier_next;
      cnt_reg    <= cnt_next;
    end
  end

  assign F    = f_reg;
  assign Z    = z_reg;
  assign C    = c_reg;
  assign V    = v_reg;
  assign E    = e_reg;
  assign busy = busy_reg;
  assign done = done_reg;

endmodule

// File: tb/tb_ula_seq.sv
// Self-checking bench for ula_seq (N=8): directed cases plus randomized ops
// checked against an arithmetic reference model.
module tb_ula_seq;
  localparam int N = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           start = 1'b0;
  logic [N-1:0]   A = '0;
  logic [N-1:0]   B = '0;
  logic [3:0]     S = '0;
  logic [2*N-1:0] F;
  logic           Z, C, V, E, busy, done;

  int checks = 0;
  int failures = 0;

  ula_seq #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .S(S),
    .F(F), .Z(Z), .C(C), .V(V), .E(E), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Reference model: returns {F, Z, C, V, E} from plain integer arithmetic.
  function automatic logic [2*N+3:0] model(input logic [3:0] op, input int a, input int b);
    int full, half, mask, sa, sb, sr, f;
    bit c, v, e;
    logic [2*N-1:0] fv;
    full = 1 << N;
    half = 1 << (N - 1);
    mask = full - 1;
    sa = (a >= half) ? a - full : a;
    sb = (b >= half) ? b - full : b;
    c = 0; v = 0; e = 0; f = 0;
    case (op)
      4'd0:  f = a & b;
      4'd1:  f = a | b;
      4'd2:  begin f = a + b; c = (f >= full); sr = sa + sb; v = (sr > half - 1) || (sr < -half); end
      4'd3:  f = (~a) & mask;
      4'd4:  f = a & ~b & mask;
      4'd5:  f = (a | ~b) & mask;
      4'd6:  begin f = (a - b) & mask; c = (a < b); sr = sa - sb; v = (sr > half - 1) || (sr < -half); end
      4'd7:  f = (a < b) ? 1 : 0;
      4'd8:  f = a * b;
      4'd9:  f = (a << (b % N)) & mask;
      4'd10: f = a >> (b % N);
      default: begin f = 0; e = 1; end
    endcase
    fv = f[2*N-1:0];
    return {fv, (f == 0), c, v, e};
  endfunction

  task automatic drive(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    @(negedge clk);
    start = 1'b1; S = op; A = a; B = b;
    @(posedge clk);
    #1;
    $display("op=%h A=%h B=%h -> F=%h Z=%b C=%b V=%b E=%b done=%b busy=%b",
             op, a, b, F, Z, C, V, E, done, busy);
  endtask

  task automatic go_idle();
    @(negedge clk);
    start = 1'b0; A = $urandom; B = $urandom; S = $urandom;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({F, Z, C, V, E, busy, done} !== '0) begin
      failures++;
      $display("FAIL reset_state: got F=%h Z%b C%b V%b E%b busy%b done%b, want all 0",
               F, Z, C, V, E, busy, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add_sub();
    drive(4'd2, 8'd200, 8'd100);
    checks++;
    if ({F, Z, C, V, E, done, busy} !== {16'h012C, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL add_carry: got F=%h Z%b C%b V%b E%b done%b busy%b, want F=012C C1 done1",
               F, Z, C, V, E, done, busy);
    end
    go_idle();
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || F !== 16'h012C || C !== 1'b1) begin
      failures++;
      $display("FAIL add_hold: got done=%b F=%h C=%b, want done=0 F=012C C=1", done, F, C);
    end
    drive(4'd2, 8'd100, 8'd100);
    checks++;
    if ({F, C, V, done} !== {16'h00C8, 1'b0, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL add_ovf: got F=%h C%b V%b done%b, want F=00C8 C0 V1 done1", F, C, V, done);
    end
    drive(4'd6, 8'd5, 8'd7);
    checks++;
    if ({F, C, V, done} !== {16'h00FE, 1'b1, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL sub_borrow: got F=%h C%b V%b done%b, want F=00FE C1 V0 done1", F, C, V, done);
    end
    go_idle();
  endtask

  // MUL: busy for N cycles, result at the (N+1)th edge; start during MUL
  // and on the completing edge must be ignored, and operand changes too.
  task automatic test_mul(input logic [N-1:0] a, input logic [N-1:0] b, input bit inject);
    logic [2*N+3:0] exp;
    exp = model(4'd8, int'(a), int'(b));
    drive(4'd8, a, b);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL mul_start: got busy=%b done=%b, want busy=1 done=0", busy, done);
    end
    for (int k = 2; k <= N + 1; k++) begin
      @(negedge clk);
      A = $urandom; B = $urandom;
      if (inject && (k == 5 || k == N + 1)) begin
        start = 1'b1; S = 4'd2;
      end else begin
        start = 1'b0; S = $urandom;
      end
      @(posedge clk); #1;
      checks++;
      if (k <= N) begin
        if (busy !== 1'b1 || done !== 1'b0) begin
          failures++;
          $display("FAIL mul_busy: edge %0d got busy=%b done=%b, want busy=1 done=0", k, busy, done);
        end
      end else begin
        if ({F, Z, C, V, E, done, busy} !== {exp, 1'b1, 1'b0}) begin
          failures++;
          $display("FAIL mul_result: A=%h B=%h got F=%h Z%b C%b V%b E%b done%b busy%b, want %h done1 busy0",
                   a, b, F, Z, C, V, E, done, busy, exp);
        end
      end
    end
    $display("mul A=%h B=%h -> F=%h", a, b, F);
    go_idle();
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || F !== exp[2*N+3:4]) begin
      failures++;
      $display("FAIL mul_after: got done=%b busy=%b F=%h, want done=0 busy=0 F=%h",
               done, busy, F, exp[2*N+3:4]);
    end
  endtask

  task automatic test_reset_during_mul();
    drive(4'd8, 8'd255, 8'd255);
    go_idle();
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({F, Z, C, V, E, busy, done} !== '0) begin
      failures++;
      $display("FAIL reset_mul_async: got F=%h Z%b C%b V%b E%b busy%b done%b, want all 0",
               F, Z, C, V, E, busy, done);
    end
    for (int k = 0; k < N + 2; k++) begin
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || F !== '0) begin
        failures++;
        $display("FAIL reset_mul_hold: got done=%b busy=%b F=%h, want 0", done, busy, F);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(4'd7, 8'd3, 8'd9);
    checks++;
    if ({F, Z, E, done, busy} !== {16'h0001, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL slt_after_reset: got F=%h Z%b E%b done%b busy%b, want F=0001 done1",
               F, Z, E, done, busy);
    end
    go_idle();
  endtask

  task automatic test_reserved();
    drive(4'd15, 8'($urandom), 8'($urandom));
    checks++;
    if ({F, Z, C, V, E, done} !== {16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL reserved: got F=%h Z%b C%b V%b E%b done%b, want F=0 Z1 E1 done1",
               F, Z, C, V, E, done);
    end
    drive(4'd0, 8'hF0, 8'h0F);
    checks++;
    if ({F, Z, E, done} !== {16'h0000, 1'b1, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL and_clear_e: got F=%h Z%b E%b done%b, want F=0 Z1 E0 done1", F, Z, E, done);
    end
    go_idle();
  endtask

  task automatic test_shift();
    drive(4'd9, 8'h81, 8'd1);
    checks++;
    if (F !== 16'h0002 || done !== 1'b1) begin
      failures++;
      $display("FAIL shl: got F=%h done=%b, want F=0002 done=1", F, done);
    end
    drive(4'd10, 8'h81, 8'd7);
    checks++;
    if (F !== 16'h0001 || done !== 1'b1) begin
      failures++;
      $display("FAIL shr: got F=%h done=%b, want F=0001 done=1", F, done);
    end
    go_idle();
  endtask

  // Random single-cycle ops, issued back-to-back or with gaps, plus MULs.
  task automatic test_random();
    logic [3:0]     op;
    logic [N-1:0]   a, b;
    logic [2*N+3:0] exp;
    for (int i = 0; i < 200; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = 8'($urandom);
      b  = 8'($urandom);
      if (op == 4'd8) begin
        test_mul(a, b, 1'($urandom_range(0, 1)));
      end else begin
        exp = model(op, int'(a), int'(b));
        drive(op, a, b);
        checks++;
        if ({F, Z, C, V, E, done, busy} !== {exp, 1'b1, 1'b0}) begin
          failures++;
          $display("FAIL random_op: op=%h A=%h B=%h got F=%h Z%b C%b V%b E%b done%b busy%b, want %h done1 busy0",
                   op, a, b, F, Z, C, V, E, done, busy, exp);
        end
        if ($urandom_range(0, 2) == 0) begin
          go_idle();
          @(posedge clk); #1;
          checks++;
          if (done !== 1'b0 || {F, Z, C, V, E} !== exp) begin
            failures++;
            $display("FAIL random_hold: got done=%b F=%h, want done=0 F=%h", done, F, exp[2*N+3:4]);
          end
        end
      end
    end
    go_idle();
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_mul(8'd255, 8'd255, 1'b1);
    test_reset_during_mul();
    test_reserved();
    test_shift();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
